// File: rtl/nonce_result_queue_if.sv
// nonce_result_queue_if: nonce enqueue, transmitter send/busy handshake and queue status signals
interface nonce_result_queue_if #(parameter int ADDR_WIDTH = 4);
  logic                nonce_found;
  logic [31:0]         golden_nonce;
  logic                flush;
  logic                busy;
  logic                send;
  logic [31:0]         word;
  logic [ADDR_WIDTH:0] fill_level;
  logic                overflow;
  modport master(output nonce_found, golden_nonce, flush, busy, input send, word, fill_level, overflow);
  modport slave(input nonce_found, golden_nonce, flush, busy, output send, word, fill_level, overflow);
endinterface

// File: rtl/nonce_result_queue.sv
// nonce_result_queue: circular buffer of golden nonces feeding the serial transmitter one word per send/busy handshake.
// Optional NONCE_QUEUE_DEDUP_EN drops a strobe that repeats the last enqueued nonce.
module nonce_result_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  nonce_result_queue_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  state_t                r_state;
  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rptr, r_wptr;
  logic [ADDR_WIDTH:0]   r_fill;
  logic [31:0]           r_word;
  logic                  r_send, r_overflow;
  logic                  w_full, w_pop, w_req, w_push, w_dup;
  assign w_full = r_fill == FULL;
  // a flush cycle never starts a new pop, so stale entries cannot slip out
  assign w_pop  = r_state == IDLE && r_fill != '0 && !bus.busy && !bus.flush;
  assign w_req  = bus.nonce_found && !bus.flush && !w_dup;
  assign w_push = w_req && (!w_full || w_pop);
`ifdef NONCE_QUEUE_DEDUP_EN
  logic [31:0] r_last;
  logic        r_last_v;
  assign w_dup = r_last_v && bus.golden_nonce == r_last;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last   <= '0;
      r_last_v <= 1'b0;
    end else if (bus.flush) begin
      r_last   <= '0;
      r_last_v <= 1'b0;
    end else if (w_push) begin
      r_last   <= bus.golden_nonce;
      r_last_v <= 1'b1;
    end
`else
  assign w_dup = 1'b0;
`endif
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= bus.golden_nonce;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rptr     <= '0;
      r_wptr     <= '0;
      r_fill     <= '0;
      r_overflow <= 1'b0;
      r_word     <= '0;
      r_send     <= 1'b0;
      r_state    <= IDLE;
    end else begin
      if (bus.flush) begin
        r_rptr     <= '0;
        r_wptr     <= '0;
        r_fill     <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_fill <= r_fill + (ADDR_WIDTH+1)'(w_push) - (ADDR_WIDTH+1)'(w_pop);
        if (w_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
      // WAIT_BUSY covers the gap before the transmitter raises busy
      case (r_state)
        IDLE: if (w_pop) begin
          r_word  <= r_mem[r_rptr];
          r_send  <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          r_send  <= 1'b0;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: if (bus.busy) r_state <= WAIT_DONE;
        WAIT_DONE: if (!bus.busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  assign bus.send       = r_send;
  assign bus.word       = r_word;
  assign bus.fill_level = r_fill;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_nonce_result_queue.sv
// tb_nonce_result_queue: directed stimulus with a word scoreboard checked by a send monitor and a transmitter model.
module tb_nonce_result_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  nonce_result_queue_if #(.ADDR_WIDTH(4)) bus();
  nonce_result_queue #(.DEPTH(16), .ADDR_WIDTH(4)) dut(.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int failures = 0;
  int sends = 0;
  int tx_len = 4;
  int s0;
  logic [31:0] sb[$];
  logic hold_busy = 1'b0;
  logic tx_busy = 1'b0;
  logic prev_busy = 1'b0;
  assign bus.busy = hold_busy | tx_busy;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic push(input logic [31:0] v, input bit exp);
    bus.nonce_found = 1'b1;
    bus.golden_nonce = v;
    if (exp) sb.push_back(v);
    step();
    bus.nonce_found = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    int q = 0;
    int n = 0;
    while (q < 4 && n < max) begin
      step();
      n++;
      q = (bus.fill_level == 0 && !bus.send && !bus.busy) ? q + 1 : 0;
    end
    if (q < 4) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);
  endtask
  // transmitter: busy from the cycle after send for tx_len cycles
  initial forever begin
    @(posedge clk);
    if (bus.send === 1'b1 && !reset) begin
      #1 tx_busy = 1'b1;
      repeat (tx_len) @(posedge clk);
      #1 tx_busy = 1'b0;
    end
  end
  always @(negedge clk) begin
    if (!reset && bus.send) begin
      sends++;
      check("send_while_busy", {62'd0, bus.busy, prev_busy}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_send: got word %0h expected no send", bus.word);
      end else check("send_word", 64'(bus.word), 64'(sb.pop_front()));
    end
    prev_busy = bus.busy;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.nonce_found = 1'b0;
    bus.golden_nonce = '0;
    bus.flush = 1'b0;
    #12;
    check("rst_send", 64'(bus.send), 64'd0);
    check("rst_word", 64'(bus.word), 64'd0);
    check("rst_fill", 64'(bus.fill_level), 64'd0);
    check("rst_ovf", 64'(bus.overflow), 64'd0);
    step();
    reset = 1'b0;
    step();
    push(32'hDEADBEEF, 1);
    check("t1_fill1", 64'(bus.fill_level), 64'd1);
    check("t1_send_early", 64'(bus.send), 64'd0);
    step();
    check("t1_send", 64'(bus.send), 64'd1);
    check("t1_word", 64'(bus.word), 64'hDEADBEEF);
    check("t1_fill0", 64'(bus.fill_level), 64'd0);
    step();
    check("t1_send_once", 64'(bus.send), 64'd0);
    wait_idle(100);
    tx_len = 40;
    s0 = sends;
    push(32'h1, 1);
    push(32'h2, 1);
    push(32'h3, 1);
    wait_idle(400);
    check("t2_sends", 64'(sends - s0), 64'd3);
    tx_len = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) push(32'h100 + 32'(i), i < 16);
    check("t3_fill", 64'(bus.fill_level), 64'd16);
    check("t3_ovf", 64'(bus.overflow), 64'd1);
    hold_busy = 1'b0;
    wait_idle(600);
    check("t3_ovf_sticky", 64'(bus.overflow), 64'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("t3_ovf_flushed", 64'(bus.overflow), 64'd0);
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(32'h200 + 32'(i), 1);
    check("t4_fill", 64'(bus.fill_level), 64'd16);
    check("t4_ovf0", 64'(bus.overflow), 64'd0);
    hold_busy = 1'b0;
    push(32'h210, 1);
    check("t4_fill_same", 64'(bus.fill_level), 64'd16);
    check("t4_ovf_still0", 64'(bus.overflow), 64'd0);
    check("t4_send", 64'(bus.send), 64'd1);
    wait_idle(600);
    tx_len = 40;
    push(32'hAAAA0000, 1);
    for (int i = 1; i <= 5; i++) push(32'h300 + 32'(i), 0);
    check("t5_fill", 64'(bus.fill_level), 64'd5);
    check("t5_busy", 64'(bus.busy), 64'd1);
    s0 = sends;
    bus.flush = 1'b1;
    bus.nonce_found = 1'b1;
    bus.golden_nonce = 32'h1234;
    step();
    bus.flush = 1'b0;
    bus.nonce_found = 1'b0;
    check("t5_fill0", 64'(bus.fill_level), 64'd0);
    check("t5_word_held", 64'(bus.word), 64'hAAAA0000);
    wait_idle(200);
    check("t5_no_send", 64'(sends - s0), 64'd0);
    tx_len = 3;
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) push(32'h400 + 32'(i), i < 16);
    hold_busy = 1'b0;
    step();
    check("t6_send", 64'(bus.send), 64'd1);
    check("t6_ovf_pre", 64'(bus.overflow), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("t6_send0", 64'(bus.send), 64'd0);
    check("t6_fill0", 64'(bus.fill_level), 64'd0);
    check("t6_ovf0", 64'(bus.overflow), 64'd0);
    check("t6_word0", 64'(bus.word), 64'd0);
    sb.delete();
    step();
    reset = 1'b0;
    step();
    hold_busy = 1'b1;
`ifdef NONCE_QUEUE_DEDUP_EN
    push(32'h55, 1);
    push(32'h55, 0);
    push(32'h66, 1);
    push(32'h55, 1);
    check("t7_fill", 64'(bus.fill_level), 64'd3);
    check("t7_ovf", 64'(bus.overflow), 64'd0);
`else
    push(32'h55, 1);
    push(32'h55, 1);
    check("t7_fill", 64'(bus.fill_level), 64'd2);
`endif
    hold_busy = 1'b0;
    wait_idle(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
